// File: rtl/ray_pkg.sv
// Shared widths, the miss sentinel and the scheduler state type for the ray/box scan path.
package ray_pkg;
    localparam int INIT_W = 28;
    localparam int DIR_W  = 31;
    localparam int OBJ_W  = 56;
    localparam int T_W    = 10;
    localparam int NRM_W  = 31;

    localparam logic [T_W-1:0] T_MISS = 10'h3FF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        HOLD,
        CMP,
        DONE
    } state_t;
endpackage

// File: rtl/ray_min_tracker.sv
// Running-nearest register set: cleared per ray, replaced only by a strictly smaller non-miss t.
module ray_min_tracker
    import ray_pkg::*;
#(
    parameter int ID_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             upd_en,
    input  logic [T_W-1:0]   cand_t,
    input  logic [NRM_W-1:0] cand_normal,
    input  logic [ID_W-1:0]  cand_id,
    output logic             take,
    output logic [T_W-1:0]   best_t,
    output logic [NRM_W-1:0] best_normal,
    output logic [ID_W-1:0]  best_id,
    output logic             hit
);
    logic [T_W-1:0]   best_t_q, best_t_d;
    logic [NRM_W-1:0] best_normal_q, best_normal_d;
    logic [ID_W-1:0]  best_id_q, best_id_d;
    logic             hit_q, hit_d;

    // Strict less-than keeps the lower index on ties.
    assign take = upd_en && (cand_t != T_MISS) && (cand_t < best_t_q);

    always_comb begin
        best_t_d      = best_t_q;
        best_normal_d = best_normal_q;
        best_id_d     = best_id_q;
        hit_d         = hit_q;
        if (clr) begin
            best_t_d      = T_MISS;
            best_normal_d = '0;
            best_id_d     = '0;
            hit_d         = 1'b0;
        end else if (take) begin
            best_t_d      = cand_t;
            best_normal_d = cand_normal;
            best_id_d     = cand_id;
            hit_d         = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_t_q      <= T_MISS;
            best_normal_q <= '0;
            best_id_q     <= '0;
            hit_q         <= 1'b0;
        end else begin
            best_t_q      <= best_t_d;
            best_normal_q <= best_normal_d;
            best_id_q     <= best_id_d;
            hit_q         <= hit_d;
        end
    end

    assign best_t      = best_t_q;
    assign best_normal = best_normal_q;
    assign best_id     = best_id_q;
    assign hit         = hit_q;
endmodule

// File: rtl/ray_box_scheduler.sv
// Scans one ray over a list of boxes through an external tracer and reports the nearest hit.
// Optional: RAY_SCHED_EARLY_EXIT_EN stops the scan on the first t==0 hit.
module ray_box_scheduler
    import ray_pkg::*;
#(
    parameter int OBJ_AW     = 4,
    parameter int TRACER_LAT = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ray_valid,
    output logic              ray_ready,
    input  logic [INIT_W-1:0] ray_init,
    input  logic [DIR_W-1:0]  ray_dir,
    input  logic [OBJ_AW:0]   ray_obj_cnt,
    output logic [OBJ_AW-1:0] obj_addr,
    input  logic [OBJ_W-1:0]  obj_data,
    output logic [INIT_W-1:0] trc_init,
    output logic [DIR_W-1:0]  trc_dir,
    output logic [OBJ_W-1:0]  trc_object,
    input  logic [T_W-1:0]    trc_t,
    input  logic [NRM_W-1:0]  trc_normal,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_hit,
    output logic [T_W-1:0]    res_t,
    output logic [NRM_W-1:0]  res_normal,
    output logic [OBJ_AW-1:0] res_obj_id
);
    localparam int CW = (TRACER_LAT > 1) ? $clog2(TRACER_LAT) : 1;

    state_t              state_q, state_d;
    logic [OBJ_AW:0]     idx_q, idx_d;
    logic [OBJ_AW:0]     count_q, count_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [INIT_W-1:0]   init_q, init_d;
    logic [DIR_W-1:0]    dir_q, dir_d;
    logic [OBJ_W-1:0]    obj_q, obj_d;
    logic                res_valid_q, res_valid_d;
    logic                clr, upd_en, take;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        count_d     = count_q;
        cnt_d       = cnt_q;
        init_d      = init_q;
        dir_d       = dir_q;
        obj_d       = obj_q;
        res_valid_d = res_valid_q;
        clr         = 1'b0;
        upd_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (ray_valid) begin
                    init_d  = ray_init;
                    dir_d   = ray_dir;
                    count_d = ray_obj_cnt;
                    idx_d   = '0;
                    clr     = 1'b1;
                    state_d = (ray_obj_cnt == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                obj_d   = obj_data;
                cnt_d   = CW'(TRACER_LAT - 1);
                state_d = HOLD;
            end
            HOLD: begin
                if (cnt_q == '0) state_d = CMP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            CMP: begin
                upd_en  = 1'b1;
                idx_d   = idx_q + 1'b1;
                state_d = (idx_q == count_q - 1'b1) ? DONE : FETCH;
`ifdef RAY_SCHED_EARLY_EXIT_EN
                if (take && (trc_t == '0)) state_d = DONE;
`endif
            end
            DONE: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            count_q     <= '0;
            cnt_q       <= '0;
            init_q      <= '0;
            dir_q       <= '0;
            obj_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            cnt_q       <= cnt_d;
            init_q      <= init_d;
            dir_q       <= dir_d;
            obj_q       <= obj_d;
            res_valid_q <= res_valid_d;
        end
    end

    ray_min_tracker #(.ID_W(OBJ_AW)) u_min (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .upd_en      (upd_en),
        .cand_t      (trc_t),
        .cand_normal (trc_normal),
        .cand_id     (idx_q[OBJ_AW-1:0]),
        .take        (take),
        .best_t      (res_t),
        .best_normal (res_normal),
        .best_id     (res_obj_id),
        .hit         (res_hit)
    );

    // Address leads idx by one cycle so the synchronous RAM's data is ready for the FETCH capture.
    assign obj_addr   = idx_d[OBJ_AW-1:0];
    assign ray_ready  = (state_q == IDLE);
    assign trc_init   = init_q;
    assign trc_dir    = dir_q;
    assign trc_object = obj_q;
    assign res_valid  = res_valid_q;
endmodule

// File: tb/tb_ray_box_scheduler.sv
// Randomized + directed bench for ray_box_scheduler with a delay-line tracer model and nearest-hit reference.
module tb_ray_box_scheduler;
    localparam int OBJ_AW = 4;
    localparam int LAT    = 24;
    localparam int NOBJ   = 1 << OBJ_AW;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ray_valid = 1'b0;
    logic              ray_ready;
    logic [27:0]       ray_init = '0;
    logic [30:0]       ray_dir = '0;
    logic [OBJ_AW:0]   ray_obj_cnt = '0;
    logic [OBJ_AW-1:0] obj_addr;
    logic [55:0]       obj_data = '0;
    logic [27:0]       trc_init;
    logic [30:0]       trc_dir;
    logic [55:0]       trc_object;
    logic [9:0]        trc_t;
    logic [30:0]       trc_normal;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic              res_hit;
    logic [9:0]        res_t;
    logic [30:0]       res_normal;
    logic [OBJ_AW-1:0] res_obj_id;

    ray_box_scheduler #(.OBJ_AW(OBJ_AW), .TRACER_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .ray_valid(ray_valid), .ray_ready(ray_ready),
        .ray_init(ray_init), .ray_dir(ray_dir), .ray_obj_cnt(ray_obj_cnt),
        .obj_addr(obj_addr), .obj_data(obj_data), .trc_init(trc_init),
        .trc_dir(trc_dir), .trc_object(trc_object), .trc_t(trc_t),
        .trc_normal(trc_normal), .res_valid(res_valid), .res_ready(res_ready),
        .res_hit(res_hit), .res_t(res_t), .res_normal(res_normal),
        .res_obj_id(res_obj_id)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Object RAM (1-cycle read) and a fake tracer: t/normal are carried in the box word, delayed LAT cycles.
    logic [55:0] mem [NOBJ];
    logic [40:0] pipe [LAT];
    always @(posedge clk) obj_data <= mem[obj_addr];
    always @(posedge clk) begin
        pipe[0] <= trc_object[40:0];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign trc_t      = pipe[LAT-1][9:0];
    assign trc_normal = pipe[LAT-1][40:10];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    endtask

    logic [9:0]  t_tab [NOBJ];
    logic [30:0] n_tab [NOBJ];

    logic        exp_active = 1'b0;
    logic        exp_addr0 = 1'b0;
    int unsigned accept_cyc = 0;
    int unsigned exp_lat = 0;
    logic        exp_hit;
    logic [9:0]  exp_t;
    logic [30:0] exp_n;
    logic [3:0]  exp_id;
    logic [27:0] exp_init;
    logic [30:0] exp_dir;

    int unsigned got_lat;
    logic        got_hit;
    logic [9:0]  got_t;
    logic [30:0] got_n;
    logic [3:0]  got_id;

    // Per-cycle comparison against the model while a ray is in flight.
    always @(negedge clk) begin
        if (exp_active && rst) begin
            chk("ray_ready_busy", ray_ready, 0);
            chk("trc_init", trc_init, exp_init);
            chk("trc_dir", trc_dir, exp_dir);
            if (exp_addr0) chk("obj_addr_const", obj_addr, 0);
            if (cyc - accept_cyc < exp_lat) begin
                chk("res_valid_early", res_valid, 0);
            end else begin
                chk("res_valid", res_valid, 1);
                chk("res_hit", res_hit, exp_hit);
                chk("res_t", res_t, exp_t);
                chk("res_normal", res_normal, exp_n);
                chk("res_obj_id", res_obj_id, exp_id);
            end
        end
    end

    task automatic model(input int n);
        int scanned = 0;
        exp_t = 10'h3FF; exp_n = '0; exp_id = '0; exp_hit = 1'b0;
        for (int i = 0; i < n; i++) begin
            scanned++;
            if (t_tab[i] != 10'h3FF && t_tab[i] < exp_t) begin
                exp_t = t_tab[i]; exp_n = n_tab[i]; exp_id = 4'(i); exp_hit = 1'b1;
            end
`ifdef RAY_SCHED_EARLY_EXIT_EN
            if (t_tab[i] == 10'd0) break;
`endif
        end
        exp_lat = scanned * (LAT + 2) + 1;
    endtask

    task automatic load_mem();
        for (int i = 0; i < NOBJ; i++) mem[i] = {15'($urandom), n_tab[i], t_tab[i]};
    endtask

    task automatic start_ray(input int n);
        load_mem();
        model(n);
        @(negedge clk);
        ray_valid   = 1'b1;
        ray_init    = 28'($urandom);
        ray_dir     = 31'($urandom);
        ray_obj_cnt = 5'(n);
        exp_init    = ray_init;
        exp_dir     = ray_dir;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        exp_active = 1'b1;
        ray_valid  = 1'b0;
    endtask

    task automatic do_ray(input int n, input int rdy_delay, input bit junk);
        bit seen = 1'b0;
        start_ray(n);
        for (int k = 0; k < int'(exp_lat) + 10; k++) begin
            @(negedge clk);
            if (res_valid) begin
                seen = 1'b1;
                got_lat = cyc - accept_cyc;
                got_hit = res_hit; got_t = res_t; got_n = res_normal; got_id = res_obj_id;
                break;
            end
        end
        if (!seen) begin
            chk("res_valid_timeout", 0, 1);
            exp_active = 1'b0;
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            return;
        end
        for (int k = 0; k < rdy_delay; k++) begin
            if (junk) begin
                ray_valid   = 1'b1;
                ray_init    = 28'($urandom);
                ray_dir     = 31'($urandom);
                ray_obj_cnt = 5'($urandom_range(0, 16));
            end
            @(negedge clk);
        end
        ray_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_active = 1'b0;
        res_ready  = 1'b0;
        chk("ready_after_hs", ray_ready, 1);
        chk("valid_after_hs", res_valid, 0);
    endtask

    task automatic fill_miss();
        for (int i = 0; i < NOBJ; i++) begin
            t_tab[i] = 10'h3FF;
            n_tab[i] = 31'($urandom);
        end
    endtask

    initial begin
        fill_miss();
        load_mem();
        repeat (3) @(negedge clk);
        chk("rst_ray_ready", ray_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_t", res_t, 10'h3FF);
        chk("rst_res_hit", res_hit, 0);
        chk("rst_obj_addr", obj_addr, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Empty list: result one cycle after accept, address untouched.
        exp_addr0 = 1'b1;
        do_ray(0, 0, 0);
        exp_addr0 = 1'b0;
        chk("n0_lat", got_lat, 1);
        chk("n0_hit", got_hit, 0);
        chk("n0_t", got_t, 10'h3FF);

        fill_miss();
        t_tab[0] = 10'd50; t_tab[1] = 10'd20; t_tab[2] = 10'd80;
        do_ray(3, 0, 0);
        chk("n3_t", got_t, 10'd20);
        chk("n3_id", got_id, 1);
        chk("n3_hit", got_hit, 1);
        chk("n3_lat", got_lat, 79);
        chk("n3_normal", got_n, n_tab[1]);

        fill_miss();
        t_tab[0] = 10'd40; t_tab[1] = 10'd40;
        do_ray(2, 1, 0);
        chk("tie_id", got_id, 0);
        chk("tie_t", got_t, 10'd40);

        fill_miss();
        do_ray(2, 0, 0);
        chk("miss_hit", got_hit, 0);
        chk("miss_normal", got_n, 0);
        chk("miss_t", got_t, 10'h3FF);

        // Stalled consumer with junk requests on the ray port.
        fill_miss();
        t_tab[0] = 10'd7; t_tab[1] = 10'd3;
        do_ray(2, 10, 1);
        chk("stall_t", got_t, 10'd3);

        // Reset during HOLD of box 1.
        fill_miss();
        t_tab[0] = 10'd5; t_tab[1] = 10'd1; t_tab[2] = 10'd9; t_tab[3] = 10'd2;
        start_ray(4);
        repeat (LAT + 2 + 8) @(negedge clk);
        exp_active = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ready", ray_ready, 1);
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_t", res_t, 10'h3FF);
        chk("mid_rst_hit", res_hit, 0);
        chk("mid_rst_addr", obj_addr, 0);
        chk("mid_rst_obj", trc_object, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_ray(4, 0, 0);
        chk("post_rst_t", got_t, 10'd1);
        chk("post_rst_id", got_id, 1);

        // Full list with a zero-distance hit at box 2.
        for (int i = 0; i < NOBJ; i++) begin
            t_tab[i] = 10'($urandom_range(1, 1000));
            n_tab[i] = 31'($urandom);
        end
        t_tab[2] = 10'd0;
        do_ray(16, 0, 0);
        chk("full_id", got_id, 2);
        chk("full_t", got_t, 0);
`ifdef RAY_SCHED_EARLY_EXIT_EN
        chk("full_lat", got_lat, 79);
`else
        chk("full_lat", got_lat, 417);
`endif

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < NOBJ; i++) begin
                t_tab[i] = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom_range(0, 40));
                n_tab[i] = 31'($urandom);
            end
            do_ray(int'($urandom_range(0, 16)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
